// File: rtl/controle_pagamento_pkg.sv
// rtl/controle_pagamento_pkg.sv - shared types and constants for the payment sequencer
// Purpose: state encoding, default value width and coin denominations used by
//          controle_pagamento and its testbench.
// Ports:   none (package).
package controle_pagamento_pkg;

  localparam int LARGURA_VALOR_PADRAO = 8;

  // 3-bit state encoding of the payment sequencer
  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    COLETA  = 3'd1,
    LIBERA  = 3'd2,
    DEVOLVE = 3'd3,
    TROCO   = 3'd4,
    FIM     = 3'd5
  } estado_t;

  // Coin denominations accepted by the coin mechanism (currency units)
  localparam int MOEDA_5   = 5;
  localparam int MOEDA_10  = 10;
  localparam int MOEDA_25  = 25;
  localparam int MOEDA_50  = 50;
  localparam int MOEDA_100 = 100;

endpackage

// File: rtl/controle_pagamento_if.sv
// rtl/controle_pagamento_if.sv - handshake bundle between main controller and payment sequencer
// Purpose: groups the start, coin, cancel, dispenser and change signals.
// Ports:   master = main controller / dispensers side, slave = controle_pagamento.
interface controle_pagamento_if #(
  parameter int LV = 8
);
  logic          inicia;
  logic [LV-1:0] preco;
  logic          moeda_valida;
  logic [LV-1:0] valor_moeda;
  logic          cancela;
  logic          entrega_pronta;
  logic          troco_ack;
  logic [LV-1:0] credito;
  logic          libera_produto;
  logic [LV-1:0] troco_valor;
  logic          troco_valido;
  logic          moeda_rejeitada;
  logic          OK;
  logic          vendido;
  logic          ocupado;

  modport master (
    output inicia, preco, moeda_valida, valor_moeda, cancela, entrega_pronta, troco_ack,
    input  credito, libera_produto, troco_valor, troco_valido, moeda_rejeitada, OK,
           vendido, ocupado
  );

  modport slave (
    input  inicia, preco, moeda_valida, valor_moeda, cancela, entrega_pronta, troco_ack,
    output credito, libera_produto, troco_valor, troco_valido, moeda_rejeitada, OK,
           vendido, ocupado
  );
endinterface

// File: rtl/controle_pagamento_temporizador_espera.sv
// rtl/controle_pagamento_temporizador_espera.sv - inactivity counter for the coin collection phase
// Purpose: counts idle cycles; expirou flags the last idle cycle before auto-cancel.
// Ports:   clk, rst (sync, active-high), limpa (clear to 0), conta (increment),
//          expirou (count == TIMEOUT_CICLOS-1).
module temporizador_espera #(
  parameter int TIMEOUT_CICLOS = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic limpa,
  input  logic conta,
  output logic expirou
);
  localparam int W = $clog2(TIMEOUT_CICLOS);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (limpa)      cnt_d = '0;
    else if (conta) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expirou = (cnt_q == W'(TIMEOUT_CICLOS - 1));
endmodule

// File: rtl/controle_pagamento.sv
// rtl/controle_pagamento.sv - payment sequencer for the COMPARADOR phase of the vending controller
// Purpose: latches the price, accumulates coin credit, drives product and change
//          dispensers, refunds on cancel/timeout and pulses OK at the end.
// Ports:   clk, rst (sync, active-high), pag (slave side of controle_pagamento_if):
//          inicia/preco, moeda_valida/valor_moeda, cancela, entrega_pronta, troco_ack in;
//          credito, libera_produto, troco_valor/troco_valido, moeda_rejeitada, OK/vendido,
//          ocupado out.
module controle_pagamento
  import controle_pagamento_pkg::*;
#(
  parameter int LARGURA_VALOR  = LARGURA_VALOR_PADRAO,
  parameter int TIMEOUT_CICLOS = 1000
) (
  input  logic                 clk,
  input  logic                 rst,
  controle_pagamento_if.slave  pag
);
  localparam int LV = LARGURA_VALOR;

  estado_t       estado_q, estado_d;
  logic [LV-1:0] preco_q, preco_d;
  logic [LV-1:0] credito_q, credito_d;
  logic [LV-1:0] troco_q, troco_d;
  logic          vendido_q, vendido_d;
  logic          rejeitada_q, rejeitada_d;

  logic [LV:0]   soma;
  logic [LV-1:0] credito_nxt;
  logic          aceita;
  logic          expirou;

  // Extra carry bit exposes overflow of credit + coin
  assign soma   = {1'b0, credito_q} + {1'b0, pag.valor_moeda};
  assign aceita = (estado_q == COLETA) && pag.moeda_valida && !soma[LV];

  // Timer runs only while collecting and restarts on every accepted coin
  temporizador_espera #(
    .TIMEOUT_CICLOS(TIMEOUT_CICLOS)
  ) u_temporizador (
    .clk    (clk),
    .rst    (rst),
    .limpa  ((estado_q != COLETA) || aceita),
    .conta  ((estado_q == COLETA) && !aceita),
    .expirou(expirou)
  );

  always_comb begin
    estado_d    = estado_q;
    preco_d     = preco_q;
    credito_d   = credito_q;
    troco_d     = troco_q;
    vendido_d   = vendido_q;
    credito_nxt = aceita ? soma[LV-1:0] : credito_q;
    rejeitada_d = pag.moeda_valida && !aceita;

    unique case (estado_q)
      OCIOSO: begin
        if (pag.inicia) begin
          preco_d   = pag.preco;
          credito_d = '0;
          vendido_d = 1'b0;
          estado_d  = COLETA;
        end
      end
      COLETA: begin
        // Coin is accounted before cancel/timeout so a refund includes it
        credito_d = credito_nxt;
        if (pag.cancela || (expirou && !aceita)) begin
          estado_d = DEVOLVE;
        end else if (credito_nxt >= preco_q) begin
          estado_d  = LIBERA;
          vendido_d = 1'b1;
        end
      end
      LIBERA: begin
        if (pag.entrega_pronta) begin
          if (credito_q > preco_q) begin
            troco_d  = credito_q - preco_q;
            estado_d = TROCO;
          end else begin
            credito_d = '0;
            estado_d  = FIM;
          end
        end
      end
      DEVOLVE: begin
        if (credito_q == '0) begin
          estado_d = FIM;
        end else begin
          troco_d  = credito_q;
          estado_d = TROCO;
        end
      end
      TROCO: begin
        if (pag.troco_ack) begin
          credito_d = '0;
          estado_d  = FIM;
        end
      end
      FIM:     estado_d = OCIOSO;
      default: estado_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q    <= OCIOSO;
      preco_q     <= '0;
      credito_q   <= '0;
      troco_q     <= '0;
      vendido_q   <= 1'b0;
      rejeitada_q <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      preco_q     <= preco_d;
      credito_q   <= credito_d;
      troco_q     <= troco_d;
      vendido_q   <= vendido_d;
      rejeitada_q <= rejeitada_d;
    end
  end

  assign pag.credito         = credito_q;
  assign pag.troco_valor     = troco_q;
  assign pag.moeda_rejeitada = rejeitada_q;
  assign pag.libera_produto  = (estado_q == LIBERA);
  assign pag.troco_valido    = (estado_q == TROCO);
  assign pag.OK              = (estado_q == FIM);
  assign pag.vendido         = (estado_q == FIM) && vendido_q;
  assign pag.ocupado         = (estado_q != OCIOSO);
endmodule

// File: tb/tb_controle_pagamento.sv
// tb/tb_controle_pagamento.sv - self-checking bench for controle_pagamento
module tb_controle_pagamento;
  import controle_pagamento_pkg::*;

  localparam int LV   = 8;
  localparam int T    = 8;
  localparam int MAXV = 255;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  controle_pagamento_if #(.LV(LV)) pag ();

  controle_pagamento #(
    .LARGURA_VALOR (LV),
    .TIMEOUT_CICLOS(T)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pag(pag)
  );

  typedef struct {
    int preco;
    int moedas[8];
    int n;
    int modo;      // 0 = wait for timeout, 1 = cancel after coins
    int troco;
    int vendido;
  } vetor_t;

  typedef struct {
    bit [7:0] aceita;
    int       usadas;
    int       venda;
    int       credito;
    int       troco;
  } modelo_t;

  task automatic chk(input string nome, input int atual, input int esperado);
    checks++;
    if (atual != esperado) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nome, atual, esperado);
    end
  endtask

  task automatic passo();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level reference: coins in order, each accepted if it fits in LV bits,
  // sale as soon as credit reaches the price; a zero price sells on the first cycle.
  function automatic modelo_t modelo(input int preco, input int moedas[8], input int n);
    modelo_t m;
    m.aceita  = '0;
    m.usadas  = 0;
    m.venda   = 0;
    m.credito = 0;
    for (int i = 0; i < n; i++) begin
      if (m.venda != 0) break;
      m.usadas++;
      if (m.credito + moedas[i] <= MAXV) begin
        m.credito  += moedas[i];
        m.aceita[i] = 1'b1;
      end
      if (m.credito >= preco) m.venda = 1;
    end
    if (n == 0 && preco == 0) m.venda = 1;
    m.troco = (m.venda != 0) ? m.credito - preco : m.credito;
    return m;
  endfunction

  function automatic vetor_t vet(input int preco, input int a, input int b, input int c,
                                 input int d, input int n, input int modo,
                                 input int troco, input int vend);
    vetor_t v;
    v.preco  = preco;
    v.moedas = '{a, b, c, d, 0, 0, 0, 0};
    v.n      = n;
    v.modo   = modo;
    v.troco  = troco;
    v.vendido = vend;
    return v;
  endfunction

  task automatic esperar_ocioso();
    int k;
    k = 0;
    while (pag.ocupado && k < 20) begin
      passo();
      k++;
    end
    if (k == 20) begin
      checks++;
      failures++;
      $display("FAIL esperar_ocioso: ocupado still %0d after 20 cycles, expected 0", pag.ocupado);
      rst = 1'b1;
      passo();
      rst = 1'b0;
    end
  endtask

  task automatic transacao(input int preco, input int moedas[8], input int n, input int modo,
                           output int obs_troco, output int obs_vendido);
    modelo_t m;
    int      t;
    int      d;
    bit      mv;
    m = modelo(preco, moedas, n);
    obs_troco = 0;
    pag.inicia = 1'b1;
    pag.preco  = LV'(preco);
    passo();
    pag.inicia = 1'b0;
    chk("ocupado_inicio", int'(pag.ocupado), 1);
    chk("credito_inicio", int'(pag.credito), 0);
    t = 0;
    for (int i = 0; i < m.usadas; i++) begin
      pag.moeda_valida = 1'b1;
      pag.valor_moeda  = LV'(moedas[i]);
      passo();
      pag.moeda_valida = 1'b0;
      chk("moeda_rejeitada", int'(pag.moeda_rejeitada), int'(!m.aceita[i]));
      t = m.aceita[i] ? 0 : t + 1;
      if (i == m.usadas - 1) begin
        chk("credito_apos_moedas", int'(pag.credito), m.credito);
      end else if (m.aceita[i]) begin
        d = $urandom_range(0, 1);
        repeat (d) passo();
        t += d;
      end
    end
    if (m.venda != 0) begin
      if (m.usadas == 0) passo();
      chk("libera_produto", int'(pag.libera_produto), 1);
      d = $urandom_range(0, 3);
      for (int k = 0; k < d; k++) begin
        mv = 1'($urandom_range(0, 1));
        pag.moeda_valida = mv;
        pag.valor_moeda  = LV'(MOEDA_5);
        pag.cancela      = 1'($urandom_range(0, 1));
        passo();
        pag.moeda_valida = 1'b0;
        pag.cancela      = 1'b0;
        chk("rejeita_em_libera", int'(pag.moeda_rejeitada), int'(mv));
        chk("libera_mantido", int'(pag.libera_produto), 1);
        chk("credito_em_libera", int'(pag.credito), m.credito);
      end
      pag.entrega_pronta = 1'b1;
      passo();
      pag.entrega_pronta = 1'b0;
    end else begin
      if (modo == 1) begin
        pag.cancela = 1'b1;
        passo();
        pag.cancela = 1'b0;
      end else begin
        repeat (T - t) passo();
        chk("timeout_nao_antes", int'(pag.OK | pag.troco_valido), 0);
      end
      chk("credito_devolve", int'(pag.credito), m.credito);
      passo();
    end
    if (pag.troco_valido) begin
      obs_troco = int'(pag.troco_valor);
      chk("credito_em_troco", int'(pag.credito), m.credito);
      d = $urandom_range(0, 2);
      repeat (d) begin
        passo();
        chk("troco_estavel", int'(pag.troco_valor), obs_troco);
        chk("troco_valido_mantido", int'(pag.troco_valido), 1);
      end
      pag.troco_ack = 1'b1;
      passo();
      pag.troco_ack = 1'b0;
    end
    chk("OK_pulso", int'(pag.OK), 1);
    obs_vendido = int'(pag.vendido);
    chk("credito_zerado", int'(pag.credito), 0);
    passo();
    chk("OK_um_ciclo", int'(pag.OK), 0);
    chk("ocioso_final", int'(pag.ocupado), 0);
    esperar_ocioso();
  endtask

  vetor_t  tabela[9];
  modelo_t mr;
  int      moedas_r[8];
  int      denom[5];
  int      ot, ov, pr, nr, md, ok_visto;

  initial begin
    rst = 1'b1;
    pag.inicia = 1'b0; pag.preco = '0; pag.moeda_valida = 1'b0; pag.valor_moeda = '0;
    pag.cancela = 1'b0; pag.entrega_pronta = 1'b0; pag.troco_ack = 1'b0;
    repeat (3) passo();
    chk("reset_credito", int'(pag.credito), 0);
    chk("reset_troco_valor", int'(pag.troco_valor), 0);
    chk("reset_saidas_1bit", int'({pag.libera_produto, pag.troco_valido, pag.moeda_rejeitada,
                                   pag.OK, pag.vendido, pag.ocupado}), 0);
    rst = 1'b0;
    passo();

    tabela[0] = vet(150, 100, 50, 0, 0, 2, 1, 0, 1);    // exact pay
    tabela[1] = vet(120, 100, 50, 0, 0, 2, 1, 30, 1);   // change
    tabela[2] = vet(200, 50, 25, 0, 0, 2, 1, 75, 0);    // cancel with credit
    tabela[3] = vet(200, 0, 0, 0, 0, 0, 1, 0, 0);       // cancel with no credit
    tabela[4] = vet(100, 50, 0, 0, 0, 1, 0, 50, 0);     // timeout refund
    tabela[5] = vet(255, 100, 100, 50, 10, 4, 1, 250, 0); // overflow coin rejected
    tabela[6] = vet(0, 0, 0, 0, 0, 0, 1, 0, 1);         // zero price, no coin
    tabela[7] = vet(0, 25, 0, 0, 0, 1, 1, 25, 1);       // zero price, coin becomes change
    tabela[8] = vet(100, 0, 0, 0, 0, 0, 0, 0, 0);       // timeout with no credit

    for (int i = 0; i < 9; i++) begin
      transacao(tabela[i].preco, tabela[i].moedas, tabela[i].n, tabela[i].modo, ot, ov);
      chk($sformatf("tabela%0d_troco", i), ot, tabela[i].troco);
      chk($sformatf("tabela%0d_vendido", i), ov, tabela[i].vendido);
    end

    // Coin while idle is rejected for exactly one cycle
    pag.moeda_valida = 1'b1; pag.valor_moeda = LV'(MOEDA_25);
    passo();
    pag.moeda_valida = 1'b0;
    chk("ocioso_moeda_rejeitada", int'(pag.moeda_rejeitada), 1);
    chk("ocioso_credito", int'(pag.credito), 0);
    passo();
    chk("ocioso_rejeita_um_ciclo", int'(pag.moeda_rejeitada), 0);

    // Coin and cancel in the same cycle: refund includes the coin
    pag.inicia = 1'b1; pag.preco = LV'(200);
    passo();
    pag.inicia = 1'b0;
    pag.moeda_valida = 1'b1; pag.valor_moeda = LV'(MOEDA_50); pag.cancela = 1'b1;
    passo();
    pag.moeda_valida = 1'b0; pag.cancela = 1'b0;
    chk("moeda_cancela_credito", int'(pag.credito), 50);
    passo();
    chk("moeda_cancela_troco_valido", int'(pag.troco_valido), 1);
    chk("moeda_cancela_troco", int'(pag.troco_valor), 50);
    pag.troco_ack = 1'b1;
    passo();
    pag.troco_ack = 1'b0;
    chk("moeda_cancela_ok", int'({pag.OK, pag.vendido}), 2);
    passo();
    esperar_ocioso();

    // inicia while busy must not re-latch the price or clear credit
    pag.inicia = 1'b1; pag.preco = LV'(100);
    passo();
    pag.moeda_valida = 1'b1; pag.valor_moeda = LV'(MOEDA_50); pag.inicia = 1'b0;
    passo();
    pag.moeda_valida = 1'b0; pag.inicia = 1'b1; pag.preco = LV'(20);
    passo();
    pag.inicia = 1'b0;
    pag.moeda_valida = 1'b1; pag.valor_moeda = LV'(MOEDA_25);
    passo();
    pag.moeda_valida = 1'b0;
    chk("inicia_ocupado_credito", int'(pag.credito), 75);
    chk("inicia_ocupado_sem_libera", int'(pag.libera_produto), 0);
    pag.cancela = 1'b1;
    passo();
    pag.cancela = 1'b0;
    passo();
    chk("inicia_ocupado_troco", int'(pag.troco_valor), 75);
    pag.troco_ack = 1'b1;
    passo();
    pag.troco_ack = 1'b0;
    chk("inicia_ocupado_ok", int'({pag.OK, pag.vendido}), 2);
    passo();
    esperar_ocioso();

    // Reset while dispensing: everything drops, no OK pulse, next sale works
    pag.inicia = 1'b1; pag.preco = LV'(10);
    passo();
    pag.inicia = 1'b0;
    pag.moeda_valida = 1'b1; pag.valor_moeda = LV'(MOEDA_25);
    passo();
    pag.moeda_valida = 1'b0;
    chk("pre_reset_libera", int'(pag.libera_produto), 1);
    rst = 1'b1;
    passo();
    rst = 1'b0;
    chk("pos_reset_saidas_1bit", int'({pag.libera_produto, pag.troco_valido, pag.OK,
                                       pag.vendido, pag.ocupado}), 0);
    chk("pos_reset_credito", int'(pag.credito), 0);
    ok_visto = 0;
    repeat (3) begin
      passo();
      ok_visto |= int'(pag.OK);
    end
    chk("pos_reset_sem_ok", ok_visto, 0);
    moedas_r = '{25, 25, 0, 0, 0, 0, 0, 0};
    transacao(40, moedas_r, 2, 1, ot, ov);
    chk("pos_reset_troco", ot, 10);
    chk("pos_reset_vendido", ov, 1);

    // Randomized transactions against the reference model
    denom = '{MOEDA_5, MOEDA_10, MOEDA_25, MOEDA_50, MOEDA_100};
    for (int r = 0; r < 40; r++) begin
      pr = $urandom_range(1, MAXV);
      nr = $urandom_range(1, 6);
      md = $urandom_range(0, 1);
      for (int j = 0; j < 8; j++) moedas_r[j] = denom[$urandom_range(0, 4)];
      mr = modelo(pr, moedas_r, nr);
      transacao(pr, moedas_r, nr, md, ot, ov);
      chk($sformatf("aleatorio%0d_troco", r), ot, mr.troco);
      chk($sformatf("aleatorio%0d_vendido", r), ov, mr.venda);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
